// File: rtl/ram_output_collector.sv
// Deskews the row-staggered result stream from the right edge of the systolic
// array into an NxN row-major RAM and serves it through an oe-gated read port.
module ram_output_collector #(
  parameter int DW  = 16,
  parameter int N   = 4,
  parameter int LAT = 0,
  parameter int AW  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  input  logic [AW-1:0] addr_out,
  input  logic          oe,
  output logic [DW-1:0] q,
  output logic          busy,
  output logic          done
);

  localparam int DEPTH = N * N;
  localparam int CW    = $clog2(LAT + 2 * N);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] lane [4];
  logic [N-1:0]  wr_en;
  logic [AW-1:0] wr_addr [N];
  int            t;

  assign lane[0] = d0;
  assign lane[1] = d1;
  assign lane[2] = d2;
  assign lane[3] = d3;

  // Lane k lags lane 0 by k cycles, so its column index is t-k.
  always_comb begin
    t = int'({1'b0, cnt}) - LAT;
    for (int k = 0; k < N; k++) begin
      wr_en[k]   = 1'b0;
      wr_addr[k] = '0;
      if (state == CAPTURE && (t - k) >= 0 && (t - k) < N) begin
        wr_en[k]   = 1'b1;
        wr_addr[k] = AW'(k * N + t - k);
      end
    end
  end

  // cnt holds in DONE, so it never wraps between passes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        CAPTURE: begin
          cnt <= cnt + 1'b1;
          if (t == 2 * N - 2) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            state <= CAPTURE;
            cnt   <= '0;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (wr_en[k]) ram[wr_addr[k]] <= lane[k];
      end
    end
  end

  assign busy = (state == CAPTURE);

  // Gating on DONE hides stale words while a new pass is overwriting them.
  assign q = (oe && state == DONE && {1'b0, addr_out} < (AW + 1)'(DEPTH)) ? ram[addr_out] : '0;

endmodule

// File: tb/tb_ram_output_collector.sv
// Directed bench for ram_output_collector: one LAT=0 instance and one LAT=2
// instance sharing clock, reset and lane inputs.
module tb_ram_output_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1, oe0, oe1;
  logic [15:0] d0, d1, d2, d3;
  logic [3:0]  addr0, addr1;
  logic [15:0] q0, q1;
  logic        busy0, done0, busy1, done1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ram_output_collector #(.DW(16), .N(4), .LAT(0), .AW(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .addr_out(addr0), .oe(oe0), .q(q0), .busy(busy0), .done(done0)
  );

  ram_output_collector #(.DW(16), .N(4), .LAT(2), .AW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .addr_out(addr1), .oe(oe1), .q(q1), .busy(busy1), .done(done1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pat(input int k, input int c);
    logic [7:0] hi, lo;
    hi = 8'(k);
    lo = 8'(c);
    return {hi, lo};
  endfunction

  // mode 0: 16'h0k0c pattern; mode 1: constant v. Outside a lane's window drive 16'hFFFF.
  task automatic set_lanes(input int t, input int mode, input logic [15:0] v);
    logic [15:0] w [4];
    for (int k = 0; k < 4; k++) begin
      int c;
      c = t - k;
      if (c >= 0 && c < 4) w[k] = (mode == 0) ? pat(k, c) : v;
      else w[k] = 16'hFFFF;
    end
    d0 = w[0]; d1 = w[1]; d2 = w[2]; d3 = w[3];
  endtask

  task automatic do_pass(input int mode, input logic [15:0] v);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_lanes(i, mode, v);
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    oe0 = 1'b1; addr0 = 4'd5; oe1 = 1'b0; addr1 = 4'd0;
    set_lanes(-10, 0, 16'h0);
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done0); end
    checks++; if (q0 !== 16'h0) begin errors++; $display("FAIL reset_q: got %h expected 0000", q0); end
    step(); step();
    rst_n = 1'b1;
    step();
    checks++; if (q0 !== 16'h0) begin errors++; $display("FAIL idle_read: got %h expected 0000", q0); end
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL reset_lat2: got busy=%b done=%b expected 0 0", busy1, done1); end
  endtask

  task automatic test_capture();
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_lanes(i, 0, 16'h0);
      oe0 = 1'b1;
      addr0 = 4'(i * 2 + 1);
      #1;
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL capture_busy[%0d]: got %b expected 1", i, busy0); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL capture_done[%0d]: got %b expected 0", i, done0); end
      checks++; if (q0 !== 16'h0) begin errors++; $display("FAIL capture_q[%0d]: got %h expected 0000", i, q0); end
      step();
    end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL capture_end_busy: got %b expected 0", busy0); end
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL capture_end_done: got %b expected 1", done0); end
    for (int a = 0; a < 16; a++) begin
      addr0 = 4'(a);
      #1;
      checks++; if (q0 !== pat(a / 4, a % 4)) begin errors++; $display("FAIL capture_read[%0d]: got %h expected %h", a, q0, pat(a / 4, a % 4)); end
    end
  endtask

  task automatic test_gating();
    oe0 = 1'b0; addr0 = 4'd5;
    #1;
    checks++; if (q0 !== 16'h0) begin errors++; $display("FAIL gate_oe0: got %h expected 0000", q0); end
    oe0 = 1'b1;
    #1;
    checks++; if (q0 !== 16'h0101) begin errors++; $display("FAIL gate_oe1: got %h expected 0101", q0); end
  endtask

  task automatic test_back_to_back();
    do_pass(1, 16'hAAAA);
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL b2b_pass1_done: got %b expected 1", done0); end
    start0 = 1'b1; oe0 = 1'b1; addr0 = 4'd0;
    #1;
    checks++; if (q0 !== 16'hAAAA) begin errors++; $display("FAIL b2b_start_cycle_q: got %h expected aaaa", q0); end
    step();
    start0 = 1'b0;
    checks++; if (done0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL b2b_restart: got done=%b busy=%b expected 0 1", done0, busy0); end
    for (int i = 0; i < 7; i++) begin
      set_lanes(i, 1, 16'h5555);
      step();
    end
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL b2b_pass2_done: got %b expected 1", done0); end
    for (int a = 0; a < 16; a++) begin
      addr0 = 4'(a);
      #1;
      checks++; if (q0 !== 16'h5555) begin errors++; $display("FAIL b2b_read[%0d]: got %h expected 5555", a, q0); end
    end
  endtask

  task automatic test_start_ignored();
    start0 = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      start0 = (i == 3);
      set_lanes(i, 0, 16'h0);
      #1;
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL ign_busy[%0d]: got %b expected 1", i, busy0); end
      step();
    end
    start0 = 1'b0;
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b1) begin errors++; $display("FAIL ign_end: got busy=%b done=%b expected 0 1", busy0, done0); end
    oe0 = 1'b1;
    for (int a = 0; a < 16; a++) begin
      addr0 = 4'(a);
      #1;
      checks++; if (q0 !== pat(a / 4, a % 4)) begin errors++; $display("FAIL ign_read[%0d]: got %h expected %h", a, q0, pat(a / 4, a % 4)); end
    end
  endtask

  task automatic test_reset_mid();
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_lanes(i, 1, 16'h9999);
      step();
    end
    rst_n = 1'b0;
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done0); end
    step();
    rst_n = 1'b1;
    step();
    do_pass(0, 16'h0);
    checks++; if (done0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL midrst_pass_end: got done=%b busy=%b expected 1 0", done0, busy0); end
    oe0 = 1'b1;
    for (int a = 0; a < 16; a++) begin
      addr0 = 4'(a);
      #1;
      checks++; if (q0 !== pat(a / 4, a % 4)) begin errors++; $display("FAIL midrst_read[%0d]: got %h expected %h", a, q0, pat(a / 4, a % 4)); end
    end
  endtask

  task automatic test_lat2();
    oe1 = 1'b1; addr1 = 4'd0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_lanes(i - 2, 0, 16'h0);
      if (i < 2) begin d0 = 16'hBEEF; d1 = 16'hBEEF; d2 = 16'hBEEF; d3 = 16'hBEEF; end
      #1;
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL lat2_busy[%0d]: got %b expected 1", i, busy1); end
      step();
    end
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b1) begin errors++; $display("FAIL lat2_end: got busy=%b done=%b expected 0 1", busy1, done1); end
    for (int a = 0; a < 16; a++) begin
      addr1 = 4'(a);
      #1;
      checks++; if (q1 !== pat(a / 4, a % 4)) begin errors++; $display("FAIL lat2_read[%0d]: got %h expected %h", a, q1, pat(a / 4, a % 4)); end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_gating();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    test_lat2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
